// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types and bus layout for the register-file write-port arbiter.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
//
// The writeback bus layout {we[37], waddr[36:32], wdata[31:0]} is shared with wb_stage.
// The long-latency result bus is {waddr[36:32], wdata[31:0]}.
package rf_wr_arbiter_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    localparam int WS_TO_RF_BUS_WD = 38;
    localparam int WS_WE_BIT       = 37;
    localparam int WS_WADDR_MSB    = 36;
    localparam int WS_WADDR_LSB    = 32;
    localparam int WS_WDATA_MSB    = 31;
    localparam int WS_WDATA_LSB    = 0;

    localparam int LU_TO_RF_BUS_WD = 37;

    // One regfile write as driven onto the port.
    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] waddr;
        logic [RF_DW-1:0] wdata;
    } rf_wr_t;

    // One buffered long-latency result (same layout as the lu bus).
    typedef struct packed {
        logic [RF_AW-1:0] waddr;
        logic [RF_DW-1:0] wdata;
    } lu_ent_t;

    // Which source owns the write port this cycle.
    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_WS,
        GNT_LU,
        GNT_FORCE,
        GNT_BYP
    } gnt_e;

    // Address match that never fires on $0.
    function automatic logic addr_hit(input logic [RF_AW-1:0] a, input logic [RF_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// In-order buffer of long-latency results, with per-entry valid bits for WAW squashing.
// Latency: a push is visible at the head one cycle later. Head outputs and id_pend are combinational.
// Backpressure: the caller must not push when full or pop when empty. Full is reported from registered count.
//
// Ports: push/push_dat enqueue. pop dequeues the head. squash/squash_addr invalidate
//        matching entries, including a same-cycle push. head_vld/head_dat show the oldest entry.
//        full/empty/cnt report occupancy. id_pend flags a valid entry that targets id_rs/id_rt.
module rf_wr_fifo
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  lu_ent_t          push_dat,
    input  logic             pop,
    input  logic             squash,
    input  logic [RF_AW-1:0] squash_addr,
    input  logic [RF_AW-1:0] id_rs,
    input  logic [RF_AW-1:0] id_rt,
    output logic             head_vld,
    output lu_ent_t          head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    cnt,
    output logic             id_pend
);

    lu_ent_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt_q;
    logic             push_vld;
    logic             pend;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign cnt      = cnt_q;
    assign head_vld = vld[rd_ptr];
    assign head_dat = mem[rd_ptr];

    // A $0 result, or one overwritten by the ws write granted this cycle, goes in already dead.
    assign push_vld = (push_dat.waddr != '0) && !(squash && addr_hit(squash_addr, push_dat.waddr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
            vld    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && addr_hit(squash_addr, mem[i].waddr)) begin
                    vld[i] <= 1'b0;
                end
            end
            // Freed slots drop their valid bit so id_pend sees only live entries.
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + AW'(1);
            end
            if (push) begin
                mem[wr_ptr] <= push_dat;
                vld[wr_ptr] <= push_vld;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Valid entries always have a nonzero address, so addr_hit also keeps $0 out.
    always_comb begin
        pend = push && push_vld &&
               (addr_hit(id_rs, push_dat.waddr) || addr_hit(id_rt, push_dat.waddr));
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (addr_hit(id_rs, mem[i].waddr) || addr_hit(id_rt, mem[i].waddr))) begin
                pend = 1'b1;
            end
        end
    end

    assign id_pend = pend;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Shares the regfile write port between wb_stage (priority) and a buffered long-latency unit.
// Latency: a ws write takes 0 cycles. A queued lu result takes at least 1 cycle, and the
//          starvation force bounds it to STARVE_LIMIT+1 cycles per queue position.
// Backpressure: lu_ready = !full from registered occupancy. ws_hold stalls WB for one forced drain cycle.
//
// Ports: ws_to_rf_bus/ws_hold connect to wb_stage. lu_valid/lu_ready/lu_waddr/lu_wdata connect
//        to the long-latency unit. id_rs/id_rt/id_pend form the decode hazard query.
//        rf_we/rf_waddr/rf_wdata drive the regfile write port. fifo_cnt is a debug occupancy count.
// Build option RF_ARB_BYPASS_EN: when the port is otherwise idle, a nonzero-address lu result
//        with an empty FIFO writes through in the same cycle instead of being enqueued.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    output logic                       ws_hold,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [RF_AW-1:0]           lu_waddr,
    input  logic [RF_DW-1:0]           lu_wdata,
    input  logic [RF_AW-1:0]           id_rs,
    input  logic [RF_AW-1:0]           id_rt,
    output logic                       id_pend,
    output logic                       rf_we,
    output logic [RF_AW-1:0]           rf_waddr,
    output logic [RF_DW-1:0]           rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    logic                       ws_we;
    logic [RF_AW-1:0]           ws_waddr;
    logic [RF_DW-1:0]           ws_wdata;
    logic [LU_TO_RF_BUS_WD-1:0] lu_bus;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       head_vld;
    lu_ent_t                    head_dat;

    gnt_e                       gnt;
    rf_wr_t                     wr;
    logic                       pop;
    logic                       push;
    logic                       squash;

    logic [SW-1:0]              starve_q;
    logic [SW-1:0]              starve_d;
    logic                       force_q;

    assign ws_we    = ws_to_rf_bus[WS_WE_BIT];
    assign ws_waddr = ws_to_rf_bus[WS_WADDR_MSB:WS_WADDR_LSB];
    assign ws_wdata = ws_to_rf_bus[WS_WDATA_MSB:WS_WDATA_LSB];
    assign lu_bus   = {lu_waddr, lu_wdata};

    // Grant priority: forced drain, writeback, queued lu, optional same-cycle bypass.
    // Nothing is granted while reset is held, so the port is quiet immediately.
    always_comb begin
        gnt = GNT_NONE;
        if (reset) begin
            gnt = GNT_NONE;
        end else if (force_q) begin
            gnt = GNT_FORCE;
        end else if (ws_we) begin
            gnt = GNT_WS;
        end else if (!fifo_empty) begin
            gnt = GNT_LU;
`ifdef RF_ARB_BYPASS_EN
        end else if (lu_valid && (lu_waddr != '0)) begin
            gnt = GNT_BYP;
`endif
        end else begin
            gnt = GNT_NONE;
        end
    end

    // Writes to $0 are consumed but never reach the regfile. A squashed head pops with we=0.
    always_comb begin
        wr = '0;
        case (gnt)
            GNT_FORCE, GNT_LU: wr = '{we: head_vld, waddr: head_dat.waddr, wdata: head_dat.wdata};
            GNT_WS:            wr = '{we: (ws_waddr != '0), waddr: ws_waddr, wdata: ws_wdata};
            GNT_BYP:           wr = '{we: 1'b1, waddr: lu_waddr, wdata: lu_wdata};
            default:           wr = '0;
        endcase
    end

    assign pop      = (gnt == GNT_FORCE) || (gnt == GNT_LU);
    assign squash   = (gnt == GNT_WS) && (ws_waddr != '0);
    assign lu_ready = !fifo_full;
    assign push     = lu_valid && lu_ready && !reset && (gnt != GNT_BYP);

    assign rf_we    = wr.we;
    assign rf_waddr = wr.waddr;
    assign rf_wdata = wr.wdata;
    assign ws_hold  = force_q;

    // The counter measures how long the current head has been passed over. Reaching the limit
    // arms a one-cycle force. The forced pop clears the counter, which drops the force again.
    assign starve_d = (fifo_empty || pop) ? '0 : starve_q + SW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            force_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            force_q  <= (starve_d == STARVE_MAX);
        end
    end

    rf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_dat    (lu_ent_t'(lu_bus)),
        .pop         (pop),
        .squash      (squash),
        .squash_addr (ws_waddr),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .head_vld    (head_vld),
        .head_dat    (head_dat),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .cnt         (fifo_cnt),
        .id_pend     (id_pend)
    );

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus a randomized run against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_wr_arbiter;

    localparam int FD = 2;
    localparam int SL = 4;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [37:0]   ws_to_rf_bus;
    logic          ws_hold;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_waddr;
    logic [31:0]   lu_wdata;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_pend;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [CW-1:0] fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    // Regfile stand-in written from the port, used to confirm surviving values.
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    rf_wr_arbiter #(
        .FIFO_DEPTH   (FD),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ws_to_rf_bus (ws_to_rf_bus),
        .ws_hold      (ws_hold),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_waddr     (lu_waddr),
        .lu_wdata     (lu_wdata),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_pend      (id_pend),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fifo_cnt     (fifo_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ws_to_rf_bus = '0;
        lu_valid     = 1'b0;
        lu_waddr     = '0;
        lu_wdata     = '0;
        id_rs        = '0;
        id_rt        = '0;
    endtask

    task automatic drive_ws(input logic we, input logic [4:0] a, input logic [31:0] d);
        ws_to_rf_bus = {we, a, d};
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid = v;
        lu_waddr = a;
        lu_wdata = d;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({rf_we, ws_hold, id_pend, lu_ready, fifo_cnt, rf_waddr, rf_wdata} !==
            {1'b0, 1'b0, 1'b0, 1'b1, CW'(0), 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got we=%b hold=%b pend=%b rdy=%b cnt=%0d a=%0d d=%h, want 0 0 0 1 0 0 0",
                     rf_we, ws_hold, id_pend, lu_ready, fifo_cnt, rf_waddr, rf_wdata);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ws_write;
        idle();
        drive_ws(1'b1, 5'd5, 32'h11);
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata, ws_hold} !== {1'b1, 5'd5, 32'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL ws_write: got we=%b a=%0d d=%h hold=%b, want 1 5 11 0", rf_we, rf_waddr, rf_wdata, ws_hold);
        end
        tick();
        drive_ws(1'b1, 5'd0, 32'hDEAD);
        #1;
        n_checks++;
        if ({rf_we, ws_hold} !== 2'b00) begin
            n_fail++;
            $display("FAIL ws_write_r0: got we=%b hold=%b, want 0 0", rf_we, ws_hold);
        end
        tick();
        idle();
    endtask

    task automatic test_lu_push;
        idle();
        drive_lu(1'b1, 5'd7, 32'hAA);
        id_rs = 5'd7;
        #1;
        n_checks++;
`ifdef RF_ARB_BYPASS_EN
        if ({rf_we, rf_waddr, rf_wdata, id_pend, lu_ready} !== {1'b1, 5'd7, 32'hAA, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL lu_bypass: got we=%b a=%0d d=%h pend=%b rdy=%b, want 1 7 aa 0 1",
                     rf_we, rf_waddr, rf_wdata, id_pend, lu_ready);
        end
`else
        if ({rf_we, id_pend, lu_ready, fifo_cnt} !== {1'b0, 1'b1, 1'b1, CW'(0)}) begin
            n_fail++;
            $display("FAIL lu_push: got we=%b pend=%b rdy=%b cnt=%0d, want 0 1 1 0", rf_we, id_pend, lu_ready, fifo_cnt);
        end
`endif
        tick();
        idle();
        id_rs = 5'd7;
        #1;
        n_checks++;
`ifdef RF_ARB_BYPASS_EN
        if ({rf_we, fifo_cnt, id_pend} !== {1'b0, CW'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL lu_bypass_after: got we=%b cnt=%0d pend=%b, want 0 0 0", rf_we, fifo_cnt, id_pend);
        end
`else
        if ({rf_we, rf_waddr, rf_wdata, fifo_cnt, id_pend} !== {1'b1, 5'd7, 32'hAA, CW'(1), 1'b1}) begin
            n_fail++;
            $display("FAIL lu_drain: got we=%b a=%0d d=%h cnt=%0d pend=%b, want 1 7 aa 1 1",
                     rf_we, rf_waddr, rf_wdata, fifo_cnt, id_pend);
        end
`endif
        tick();
        #1;
        n_checks++;
        if ({rf_we, fifo_cnt} !== {1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL lu_empty: got we=%b cnt=%0d, want 0 0", rf_we, fifo_cnt);
        end
        idle();
    endtask

    task automatic test_starvation;
        idle();
        drive_ws(1'b1, 5'd8, 32'h80);
        drive_lu(1'b1, 5'd7, 32'h77);
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, ws_hold} !== {1'b1, 5'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL starve_push: got we=%b a=%0d hold=%b, want 1 8 0", rf_we, rf_waddr, ws_hold);
        end
        tick();
        lu_valid = 1'b0;
        for (int c = 1; c <= SL; c++) begin
            drive_ws(1'b1, 5'd8, 32'h80 + c);
            #1;
            n_checks++;
            if ({rf_we, rf_waddr, ws_hold, fifo_cnt} !== {1'b1, 5'd8, 1'b0, CW'(1)}) begin
                n_fail++;
                $display("FAIL starve_deny%0d: got we=%b a=%0d hold=%b cnt=%0d, want 1 8 0 1",
                         c, rf_we, rf_waddr, ws_hold, fifo_cnt);
            end
            tick();
        end
        drive_ws(1'b1, 5'd8, 32'h85);
        #1;
        n_checks++;
        if ({ws_hold, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd7, 32'h77}) begin
            n_fail++;
            $display("FAIL starve_force: got hold=%b we=%b a=%0d d=%h, want 1 1 7 77", ws_hold, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        #1;
        n_checks++;
        if ({ws_hold, rf_we, rf_waddr, rf_wdata, fifo_cnt} !== {1'b0, 1'b1, 5'd8, 32'h85, CW'(0)}) begin
            n_fail++;
            $display("FAIL starve_retire: got hold=%b we=%b a=%0d d=%h cnt=%0d, want 0 1 8 85 0",
                     ws_hold, rf_we, rf_waddr, rf_wdata, fifo_cnt);
        end
        tick();
        idle();
    endtask

    task automatic test_squash;
        idle();
        drive_ws(1'b1, 5'd3, 32'h33);
        drive_lu(1'b1, 5'd9, 32'h99);
        tick();
        lu_valid = 1'b0;
        drive_ws(1'b1, 5'd9, 32'h22);
        id_rs = 5'd9;
        #1;
        n_checks++;
        if ({id_pend, rf_we, rf_waddr, rf_wdata, fifo_cnt} !== {1'b1, 1'b1, 5'd9, 32'h22, CW'(1)}) begin
            n_fail++;
            $display("FAIL squash_ws: got pend=%b we=%b a=%0d d=%h cnt=%0d, want 1 1 9 22 1",
                     id_pend, rf_we, rf_waddr, rf_wdata, fifo_cnt);
        end
        tick();
        idle();
        id_rs = 5'd9;
        #1;
        n_checks++;
        if ({id_pend, rf_we, fifo_cnt} !== {1'b0, 1'b0, CW'(1)}) begin
            n_fail++;
            $display("FAIL squash_pop: got pend=%b we=%b cnt=%0d, want 0 0 1", id_pend, rf_we, fifo_cnt);
        end
        tick();
        #1;
        n_checks++;
        if ({fifo_cnt, rf_mem[9]} !== {CW'(0), 32'h22}) begin
            n_fail++;
            $display("FAIL squash_keep: got cnt=%0d r9=%h, want 0 22", fifo_cnt, rf_mem[9]);
        end
        // Push and ws write to the same register in one cycle.
        drive_ws(1'b1, 5'd10, 32'h10A);
        drive_lu(1'b1, 5'd10, 32'hBAD);
        id_rt = 5'd10;
        #1;
        n_checks++;
        if ({id_pend, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'd10}) begin
            n_fail++;
            $display("FAIL squash_same: got pend=%b we=%b a=%0d, want 0 1 10", id_pend, rf_we, rf_waddr);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if ({rf_we, fifo_cnt} !== {1'b0, CW'(1)}) begin
            n_fail++;
            $display("FAIL squash_same_pop: got we=%b cnt=%0d, want 0 1", rf_we, fifo_cnt);
        end
        tick();
        #1;
        n_checks++;
        if ({fifo_cnt, rf_mem[10]} !== {CW'(0), 32'h10A}) begin
            n_fail++;
            $display("FAIL squash_same_keep: got cnt=%0d r10=%h, want 0 10a", fifo_cnt, rf_mem[10]);
        end
    endtask

    task automatic test_back_to_back;
        idle();
        drive_ws(1'b1, 5'd1, 32'h1);
        drive_lu(1'b1, 5'd11, 32'hB1);
        tick();
        drive_lu(1'b1, 5'd12, 32'hB2);
        #1;
        n_checks++;
        if ({lu_ready, fifo_cnt} !== {1'b1, CW'(1)}) begin
            n_fail++;
            $display("FAIL full_second: got rdy=%b cnt=%0d, want 1 1", lu_ready, fifo_cnt);
        end
        tick();
        drive_lu(1'b1, 5'd13, 32'hB3);
        #1;
        n_checks++;
        if ({lu_ready, fifo_cnt} !== {1'b0, CW'(2)}) begin
            n_fail++;
            $display("FAIL full_block: got rdy=%b cnt=%0d, want 0 2", lu_ready, fifo_cnt);
        end
        tick();
        drive_ws(1'b0, 5'd0, 32'h0);
        #1;
        n_checks++;
        if ({lu_ready, fifo_cnt, rf_we, rf_waddr, rf_wdata} !== {1'b0, CW'(2), 1'b1, 5'd11, 32'hB1}) begin
            n_fail++;
            $display("FAIL full_pop: got rdy=%b cnt=%0d we=%b a=%0d d=%h, want 0 2 1 11 b1",
                     lu_ready, fifo_cnt, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        #1;
        n_checks++;
        if ({lu_ready, fifo_cnt, rf_we, rf_waddr, rf_wdata} !== {1'b1, CW'(1), 1'b1, 5'd12, 32'hB2}) begin
            n_fail++;
            $display("FAIL full_reopen: got rdy=%b cnt=%0d we=%b a=%0d d=%h, want 1 1 1 12 b2",
                     lu_ready, fifo_cnt, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        lu_valid = 1'b0;
        #1;
        n_checks++;
        if ({fifo_cnt, rf_we, rf_waddr, rf_wdata} !== {CW'(1), 1'b1, 5'd13, 32'hB3}) begin
            n_fail++;
            $display("FAIL full_third: got cnt=%0d we=%b a=%0d d=%h, want 1 1 13 b3", fifo_cnt, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        #1;
        n_checks++;
        if ({fifo_cnt, rf_we} !== {CW'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL full_drained: got cnt=%0d we=%b, want 0 0", fifo_cnt, rf_we);
        end
        idle();
    endtask

    task automatic test_reset_mid;
        idle();
        drive_ws(1'b1, 5'd1, 32'h1);
        drive_lu(1'b1, 5'd14, 32'hC4);
        tick();
        drive_lu(1'b1, 5'd15, 32'hC5);
        tick();
        idle();
        #1;
        n_checks++;
        if ({fifo_cnt, rf_we} !== {CW'(2), 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_before: got cnt=%0d we=%b, want 2 1", fifo_cnt, rf_we);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({fifo_cnt, lu_ready, rf_we, ws_hold, id_pend} !== {CW'(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got cnt=%0d rdy=%b we=%b hold=%b pend=%b, want 0 1 0 0 0",
                     fifo_cnt, lu_ready, rf_we, ws_hold, id_pend);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({fifo_cnt, rf_we} !== {CW'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL rstmid_after: got cnt=%0d we=%b, want 0 0", fifo_cnt, rf_we);
        end
    endtask

    // Reference: a queue of {addr, data, live} entries plus the age of the current head.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic        v;
    } ent_t;

    task automatic test_random;
        ent_t        mq[$];
        int          waited;
        logic        wwe, e_force, e_ready, e_we, e_pop, e_pend, sq, byp, push, pv;
        logic [4:0]  wa, e_a;
        logic [31:0] wd, e_d;

        idle();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        tick();
        waited = 0;
        for (int c = 0; c < 400; c++) begin
            wwe = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            drive_ws(wwe, wa, wd);
            drive_lu(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));

            e_force = (mq.size() > 0) && (waited == SL);
            e_ready = (mq.size() < FD);
            e_pop = 1'b0; e_we = 1'b0; e_a = '0; e_d = '0; sq = 1'b0; byp = 1'b0;
            if (e_force || (!wwe && mq.size() > 0)) begin
                e_pop = 1'b1;
                e_we  = mq[0].v;
                e_a   = mq[0].a;
                e_d   = mq[0].d;
            end else if (wwe) begin
                e_we = (wa != 0);
                e_a  = wa;
                e_d  = wd;
                sq   = (wa != 0);
            end
`ifdef RF_ARB_BYPASS_EN
            else if (lu_valid && lu_waddr != 0) begin
                byp  = 1'b1;
                e_we = 1'b1;
                e_a  = lu_waddr;
                e_d  = lu_wdata;
            end
`endif
            push = lu_valid && e_ready && !byp;
            pv   = (lu_waddr != 0) && !(sq && lu_waddr == wa);
            e_pend = push && pv && (lu_waddr == id_rs || lu_waddr == id_rt);
            foreach (mq[k]) begin
                if (mq[k].v && (mq[k].a == id_rs || mq[k].a == id_rt)) e_pend = 1'b1;
            end

            #1;
            n_checks++;
            if ({rf_we, ws_hold, lu_ready, id_pend, fifo_cnt} !== {e_we, e_force, e_ready, e_pend, CW'(mq.size())}) begin
                n_fail++;
                $display("FAIL random_flags cycle %0d: got we,hold,rdy,pend,cnt=%b,%b,%b,%b,%0d want %b,%b,%b,%b,%0d",
                         c, rf_we, ws_hold, lu_ready, id_pend, fifo_cnt, e_we, e_force, e_ready, e_pend, mq.size());
            end
            if (e_we) begin
                n_checks++;
                if ({rf_waddr, rf_wdata} !== {e_a, e_d}) begin
                    n_fail++;
                    $display("FAIL random_write cycle %0d: got a=%0d d=%h want a=%0d d=%h", c, rf_waddr, rf_wdata, e_a, e_d);
                end
            end

            if (sq) begin
                foreach (mq[k]) begin
                    if (mq[k].a == wa) mq[k].v = 1'b0;
                end
            end
            if (e_pop) begin
                void'(mq.pop_front());
                waited = 0;
            end else if (mq.size() > 0) begin
                waited++;
            end else begin
                waited = 0;
            end
            if (push) mq.push_back({lu_waddr, lu_wdata, pv});
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ws_write();
        test_lu_push();
        test_starvation();
        test_squash();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
